// File: rtl/priority_arbiter_rr.sv
// Registered N-way arbiter: fixed-priority or round-robin winner selection,
// grant locked until release, optional round-robin hold timeout for fairness.
module priority_arbiter_rr #(
   parameter int N        = 4,
   parameter int IDX_W    = $clog2(N),
   parameter int MAX_HOLD = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             mode,
   input  logic [N-1:0]     req,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] grant_idx,
   output logic             valid
);

   localparam int HOLD_W     = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
   localparam int HOLD_SAT_I = (MAX_HOLD > 0) ? MAX_HOLD - 1 : (1 << HOLD_W) - 1;
   localparam logic [HOLD_W-1:0] HOLD_SAT = HOLD_W'(HOLD_SAT_I);

   typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

   state_t             r_state;
   logic [N-1:0]       r_grant;
   logic [IDX_W-1:0]   r_grant_idx;
   logic               r_valid;
   logic [IDX_W-1:0]   r_rr_ptr;
   logic [HOLD_W-1:0]  r_hold_cnt;

   state_t             w_state_nxt;
   logic [N-1:0]       w_grant_nxt;
   logic [IDX_W-1:0]   w_idx_nxt;
   logic               w_valid_nxt;
   logic [IDX_W-1:0]   w_ptr_nxt;
   logic [HOLD_W-1:0]  w_hold_nxt;
   logic [N-1:0]       w_arb_req;
   logic               w_load;
   logic               w_timeout;
   logic [IDX_W-1:0]   w_win;

   // Fixed: highest set index. Round-robin: distance from rr_ptr going downward
   // (rr_ptr-1 is distance 1, rr_ptr itself is distance N); smallest distance wins.
   function automatic logic [IDX_W-1:0] f_pick(input logic [N-1:0] v,
                                                input logic m,
                                                input logic [IDX_W-1:0] ptr);
      logic [IDX_W-1:0] win;
      int               best;
      int               d;
      win  = '0;
      best = N + 1;
      for (int i = 0; i < N; i++) begin
         d = int'(ptr) - i;
         if (d <= 0) d = d + N;
         if (v[i]) begin
            if (!m) begin
               win = IDX_W'(i);
            end else if (d < best) begin
               best = d;
               win  = IDX_W'(i);
            end
         end
      end
      return win;
   endfunction

   assign w_timeout = mode && (MAX_HOLD > 0) && (r_hold_cnt == HOLD_SAT);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_grant     <= '0;
         r_grant_idx <= '0;
         r_valid     <= 1'b0;
         r_rr_ptr    <= '0;
         r_hold_cnt  <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_grant     <= w_grant_nxt;
         r_grant_idx <= w_idx_nxt;
         r_valid     <= w_valid_nxt;
         r_rr_ptr    <= w_ptr_nxt;
         r_hold_cnt  <= w_hold_nxt;
      end
   end

   // NOTE: every signal gets a default at the top so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_grant_nxt = r_grant;
      w_idx_nxt   = r_grant_idx;
      w_valid_nxt = r_valid;
      w_ptr_nxt   = r_rr_ptr;
      w_hold_nxt  = r_hold_cnt;
      w_arb_req   = req;
      w_load      = 1'b0;
      w_win       = '0;

      unique case (r_state)
         IDLE: begin
            if (en && (|req)) begin
               w_load = 1'b1;
            end else begin
               w_grant_nxt = '0;
               w_idx_nxt   = '0;
               w_valid_nxt = 1'b0;
            end
         end
         GRANT: begin
            if (!req[r_grant_idx]) begin
               if (en && (|req)) begin
                  w_load = 1'b1;
               end else begin
                  w_state_nxt = IDLE;
                  w_grant_nxt = '0;
                  w_idx_nxt   = '0;
                  w_valid_nxt = 1'b0;
               end
            end else if (w_timeout) begin
               // Hand over to another requester if one is waiting, else re-grant.
               w_arb_req = req & ~r_grant;
               if (en && (|w_arb_req)) w_load = 1'b1;
               else                    w_hold_nxt = '0;
            end else if (r_hold_cnt != HOLD_SAT) begin
               w_hold_nxt = r_hold_cnt + 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase

      if (w_load) begin
         w_win       = f_pick(w_arb_req, mode, r_rr_ptr);
         w_state_nxt = GRANT;
         w_grant_nxt = {{(N-1){1'b0}}, 1'b1} << w_win;
         w_idx_nxt   = w_win;
         w_valid_nxt = 1'b1;
         w_ptr_nxt   = w_win;
         w_hold_nxt  = '0;
      end
   end

   always_comb begin
      grant     = r_grant;
      grant_idx = r_grant_idx;
      valid     = r_valid;
   end

endmodule

// File: tb/tb_priority_arbiter_rr.sv
// Self-checking bench: directed vectors with literal expectations, plus a
// per-cycle comparison against a behavioural model of the arbitration rules.
module tb_priority_arbiter_rr;

   localparam int N        = 4;
   localparam int IDX_W    = 2;
   localparam int MAX_HOLD = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             en;
   logic             mode;
   logic [N-1:0]     req;
   logic [N-1:0]     grant;
   logic [IDX_W-1:0] grant_idx;
   logic             valid;

   int n_tests = 0;
   int n_fail  = 0;
   bit cmp_en  = 1'b0;

   // Model state: currently granted requester (-1 = none), pointer, hold count.
   int m_cur  = -1;
   int m_ptr  = 0;
   int m_hold = 0;

   priority_arbiter_rr #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .mode      (mode),
      .req       (req),
      .grant     (grant),
      .grant_idx (grant_idx),
      .valid     (valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_out(input string name, input logic [N-1:0] g,
                          input logic [IDX_W-1:0] idx, input logic v);
      check({name, "_grant"}, 32'(grant), 32'(g));
      check({name, "_idx"},   32'(grant_idx), 32'(idx));
      check({name, "_valid"}, 32'(valid), 32'(v));
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic int pick(input logic [N-1:0] v, input logic m, input int ptr);
      int win;
      win = -1;
      if (!m) begin
         for (int i = N - 1; i >= 0; i--)
            if (win < 0 && v[i]) win = i;
      end else begin
         for (int off = 1; off <= N; off++)
            if (win < 0 && v[(ptr - off + N) % N]) win = (ptr - off + N) % N;
      end
      return win;
   endfunction

   always @(posedge clk) begin
      int nc, np, nh;
      logic [N-1:0] mk;
      nc = m_cur; np = m_ptr; nh = m_hold;
      mk = req;
      if (!rst_n) begin
         nc = -1; np = 0; nh = 0;
      end else if (m_cur < 0 || !req[m_cur]) begin
         if (en && req != '0) begin
            nc = pick(req, mode, m_ptr); np = nc; nh = 0;
         end else begin
            nc = -1;
         end
      end else if (mode && m_hold == MAX_HOLD - 1) begin
         mk[m_cur] = 1'b0;
         if (en && mk != '0) begin
            nc = pick(mk, mode, m_ptr); np = nc; nh = 0;
         end else begin
            nh = 0;
         end
      end else begin
         nh = (m_hold + 1 > MAX_HOLD - 1) ? MAX_HOLD - 1 : m_hold + 1;
      end
      m_cur  <= nc;
      m_ptr  <= np;
      m_hold <= nh;
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         check("model_grant", 32'(grant), (m_cur < 0) ? 32'd0 : (32'd1 << m_cur));
         check("model_idx",   32'(grant_idx), (m_cur < 0) ? 32'd0 : 32'(m_cur));
         check("model_valid", 32'(valid), (m_cur < 0) ? 32'd0 : 32'd1);
         check("onehot0",     32'($onehot0(grant)), 32'd1);
      end
   end

   initial begin
      int rr_seq [5];
      rr_seq = '{3, 2, 1, 0, 3};
      rst_n = 1'b0; en = 1'b0; mode = 1'b0; req = '0;
      cyc(2);
      chk_out("reset", 4'b0000, 2'd0, 1'b0);
      cmp_en = 1'b1;
      rst_n  = 1'b1;

      // Fixed priority, release with immediate re-grant and no bubble.
      mode = 1'b0; en = 1'b1; req = 4'b1100;
      cyc(1); chk_out("fp_first", 4'b1000, 2'd3, 1'b1);
      req = 4'b0100;
      cyc(1); chk_out("fp_regrant", 4'b0100, 2'd2, 1'b1);
      req = 4'b0000;
      cyc(1); chk_out("fp_idle", 4'b0000, 2'd0, 1'b0);

      // Round-robin with timeout from a fresh pointer.
      rst_n = 1'b0;
      cyc(1);
      rst_n = 1'b1; mode = 1'b1; req = 4'b1111;
      for (int r = 0; r < 5; r++)
         for (int c = 0; c < MAX_HOLD; c++) begin
            cyc(1);
            check($sformatf("rr_round%0d_cyc%0d", r, c), 32'(grant_idx), 32'(rr_seq[r]));
         end
      req = 4'b0000;
      cyc(1); chk_out("rr_idle", 4'b0000, 2'd0, 1'b0);

      // Single requester then release to IDLE.
      req = 4'b0001;
      cyc(1); chk_out("single", 4'b0001, 2'd0, 1'b1);
      req = 4'b0000;
      cyc(1); chk_out("single_release", 4'b0000, 2'd0, 1'b0);

      // en=0 blocks new grants; en=1 then grants highest.
      mode = 1'b0; en = 1'b0; req = 4'b1010;
      for (int i = 0; i < 5; i++) begin
         cyc(1); check($sformatf("en_low_valid%0d", i), 32'(valid), 32'd0);
      end
      en = 1'b1;
      cyc(1); chk_out("en_high", 4'b1000, 2'd3, 1'b1);

      // en=0 keeps a held grant until release, then IDLE.
      en = 1'b0;
      cyc(3); chk_out("en_low_hold", 4'b1000, 2'd3, 1'b1);
      req = 4'b0010;
      cyc(1); chk_out("en_low_release", 4'b0000, 2'd0, 1'b0);
      en = 1'b1;
      cyc(1); chk_out("en_back", 4'b0010, 2'd1, 1'b1);
      req = 4'b0000;
      cyc(1);

      // Lone requester in round-robin: timeout re-grants, never drops.
      mode = 1'b1; req = 4'b0010;
      for (int i = 0; i < 12; i++) begin
         cyc(1); check($sformatf("lone_grant%0d", i), 32'(grant), 32'b0010);
      end
      req = 4'b0000;
      cyc(1);

      // Reset mid-grant, then round-robin restarts from pointer 0.
      mode = 1'b0; req = 4'b0100;
      cyc(1); chk_out("pre_reset", 4'b0100, 2'd2, 1'b1);
      rst_n = 1'b0;
      cyc(1); chk_out("mid_reset", 4'b0000, 2'd0, 1'b0);
      rst_n = 1'b1; mode = 1'b1; req = 4'b1111;
      cyc(1); chk_out("post_reset", 4'b1000, 2'd3, 1'b1);
      req = 4'b0000;
      cyc(2);

      cmp_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
